ws2812_strip_driver: RTL
========================

Name: ws2812_strip_driver

Overview:
Serial driver for a chain of WS2812-class addressable LEDs on a single data line. It holds per-LED colour in an external pixel store and reads one 24-bit pixel per LED through a synchronous-read port. Each frame is NUM_LEDS pixels, transmitted back-to-back with no gaps, followed by a latch/reset low period. This block replaces the fixed 60-LED, single-colour driver with a parametrised, per-pixel, start/done-controlled engine.

Parameters:
NUM_LEDS, 60, number of LEDs in the chain (1..4096)
T0H_CYC, 4, clk cycles dout is high for a 0 bit
T1H_CYC, 12, clk cycles dout is high for a 1 bit
BIT_CYC, 16, clk cycles per bit period; must exceed T1H_CYC
RST_CYC, 8192, clk cycles dout is held low after the last bit (latch)
AUTO_REFRESH, 0, 1 = restart the frame automatically after latch, no start needed
AW, $clog2(NUM_LEDS) (min 1), pixel address width

Ports:
clk  in  1  system clock, 10 MHz nominal; all timing is in clk cycles
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to send one frame; sampled only in IDLE
pix_rd  out  1  one-cycle read strobe to the pixel store
pix_addr  out  AW  pixel index for pix_rd
pix_data  in  24  pixel {G[7:0],R[7:0],B[7:0]}, valid the cycle after pix_rd
dout  out  1  LED data line, registered
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse at the end of the latch period

Behaviour:
- Reset (async, rst_n=0): dout=0, busy=0, done=0, pix_rd=0, pix_addr=0, state IDLE, all counters 0. Asserting reset mid-frame forces dout low immediately. After release the block waits in IDLE; AUTO_REFRESH does not self-start until the first start.
- States: IDLE -> FETCH -> SEND -> LATCH -> IDLE (AUTO_REFRESH=1: LATCH -> FETCH).
- IDLE: dout=0. Edge E0 sees start=1: next state FETCH, busy=1, pix_rd=1, pix_addr=0 (all registered, visible after E0).
- FETCH: lasts one cycle. At E1, pix_data is loaded into a 24-bit shift register, bit_cnt=0, cyc_cnt=0, state SEND, and dout=1 (first rise at E1).
- SEND: cyc_cnt counts 0..BIT_CYC-1 within each bit.
  - dout=1 while cyc_cnt < (current bit ? T1H_CYC : T0H_CYC), else 0.
  - Bit order is MSB first: G7..G0, R7..R0, B7..B0.
  - At bit_cnt=0, cyc_cnt=0 of pixel k (k < NUM_LEDS-1): pix_rd=1 for one cycle with pix_addr=k+1. pix_data is captured into next_buf on the following edge.
  - At the end of bit 23 (cyc_cnt = BIT_CYC-1): if more pixels remain, load the shift register from next_buf and continue with no idle cycle. Otherwise go to LATCH.
- LATCH: dout=0 for exactly RST_CYC cycles. On the last cycle done=1 for one cycle. Then IDLE with busy=0, or FETCH with busy held 1 when AUTO_REFRESH=1.
- start while busy: ignored, not queued.
- Frame length from E1 to the start of LATCH is exactly NUM_LEDS*24*BIT_CYC cycles.
- pix_addr holds its last value between strobes.
- Widths: cyc_cnt is $clog2(BIT_CYC), bit_cnt is 5 bits, led_cnt is AW, rst counter is $clog2(RST_CYC+1). No counter wrap is ever relied upon.
- NUM_LEDS=1: no prefetch strobe is issued. pix_rd pulses exactly once per frame.

Optional Feature:
WS2812_BRIGHTNESS_EN:
- Defined: adds input port bright [7:0]. Each 8-bit channel of a fetched pixel is replaced by (chan*(bright+1))>>8, computed when the pixel is captured into the shift register or next_buf. bright=255 gives identity, bright=0 gives all-zero data. bright is sampled per pixel, so a change takes effect from the next captured pixel.
- Undefined: no bright port, and pixels are sent unmodified.

Test Plan:
1. NUM_LEDS=1, pix_data=24'h800001, one start -> dout high 12 cycles on bit 0, 4 cycles on bits 1..22, 12 cycles on bit 23. Each bit period is 16 cycles. Then 8192 low cycles, done pulse, busy=0.
2. NUM_LEDS=3, store {A50F0F, 000000, FFFFFF} -> pix_rd pulses at addr 0, 1, 2. The three pixels are sent back-to-back with no gap (1152 cycles from E1). Waveform matches per-bit T0H/T1H.
3. start re-pulsed mid-frame and again during LATCH -> no extra pix_rd, exactly one done, frame unaltered.
4. rst_n low for 1 cycle during pixel 1 of 3, while dout is high -> dout=0 asynchronously, busy=0. A fresh start then sends a complete frame from addr 0.
5. AUTO_REFRESH=1, NUM_LEDS=2, single start -> a second frame's pix_rd at addr 0 occurs on the cycle after the done pulse. busy stays high throughout.
6. WS2812_BRIGHTNESS_EN, bright=8'h7F, pixel FF8040 -> transmitted bits equal 7F4020.

Source files
------------

// File: rtl/ws2812_strip_driver.sv
// WS2812 strip driver: reads one 24-bit {G,R,B} pixel per LED from a
// synchronous-read pixel store and shifts it out MSB first as T0H/T1H pulses,
// back-to-back across the whole chain, then holds the line low for the latch.
// The next pixel is prefetched into next_buf at the start of each pixel.
// Optional feature macro: WS2812_BRIGHTNESS_EN (adds bright[7:0] scaling).
module ws2812_strip_driver #(
  parameter int NUM_LEDS     = 60,
  parameter int T0H_CYC      = 4,
  parameter int T1H_CYC      = 12,
  parameter int BIT_CYC      = 16,
  parameter int RST_CYC      = 8192,
  parameter int AUTO_REFRESH = 0,
  parameter int AW           = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0]    bright,
`endif
  output logic          pix_rd,
  output logic [AW-1:0] pix_addr,
  input  logic [23:0]   pix_data,
  output logic          dout,
  output logic          busy,
  output logic          done
);

  localparam int CW = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC + 1) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;

  localparam logic [CW-1:0] T0H_W   = CW'(T0H_CYC);
  localparam logic [CW-1:0] T1H_W   = CW'(T1H_CYC);
  localparam logic [CW-1:0] CYC_END = CW'(BIT_CYC - 1);
  localparam logic [RW-1:0] RST_END = RW'(RST_CYC - 1);
  localparam logic [AW:0]   NLED    = (AW+1)'(NUM_LEDS);

  logic [1:0]    state_q, state_d;
  logic [23:0]   sh_q, sh_d;
  logic [23:0]   nbuf_q, nbuf_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [4:0]    bit_q, bit_d;
  logic [AW-1:0] led_q, led_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_q, rd_d;
  logic          dout_q, dout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [23:0]   pix_fmt;

`ifdef WS2812_BRIGHTNESS_EN
  function automatic logic [7:0] scl(input logic [7:0] c, input logic [7:0] b);
    logic [16:0] p;
    p = {9'd0, c} * ({9'd0, b} + 17'd1);
    return p[15:8];
  endfunction
  // Scale each channel as the pixel is captured; bright is sampled per pixel.
  assign pix_fmt = {scl(pix_data[23:16], bright), scl(pix_data[15:8], bright),
                    scl(pix_data[7:0], bright)};
`else
  assign pix_fmt = pix_data;
`endif

  // Next-state logic: frame sequencing, bit timing, prefetch and latch count.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    nbuf_d  = nbuf_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    led_d   = led_q;
    rcnt_d  = rcnt_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    rd_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          busy_d  = 1'b1;
          rd_d    = 1'b1;
          addr_d  = '0;
        end
      end
      S_FETCH: begin
        sh_d    = pix_fmt;
        bit_d   = '0;
        cyc_d   = '0;
        led_d   = '0;
        state_d = S_SEND;
        if (NUM_LEDS > 1) begin
          rd_d   = 1'b1;
          addr_d = AW'(1);
        end
      end
      S_SEND: begin
        // Prefetched pixel arrives the cycle after its strobe.
        if (rd_q) nbuf_d = pix_fmt;
        if (cyc_q != CYC_END) begin
          cyc_d = cyc_q + 1'b1;
        end else begin
          cyc_d = '0;
          if (bit_q != 5'd23) begin
            bit_d = bit_q + 5'd1;
            sh_d  = {sh_q[22:0], 1'b0};
          end else if (({1'b0, led_q} + 1'b1) < NLED) begin
            bit_d = '0;
            sh_d  = nbuf_q;
            led_d = led_q + 1'b1;
            if (({1'b0, led_q} + (AW+1)'(2)) < NLED) begin
              rd_d   = 1'b1;
              addr_d = led_q + AW'(2);
            end
          end else begin
            state_d = S_LATCH;
            rcnt_d  = '0;
          end
        end
      end
      default: begin
        if (rcnt_q == RST_END) begin
          if (AUTO_REFRESH != 0) begin
            state_d = S_FETCH;
            rd_d    = 1'b1;
            addr_d  = '0;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
    endcase
    done_d = (state_d == S_LATCH) && (rcnt_d == RST_END);
    dout_d = (state_d == S_SEND) && (cyc_d < (sh_d[23] ? T1H_W : T0H_W));
  end

  // State and output registers; reset clears everything and drops dout at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      nbuf_q  <= '0;
      cyc_q   <= '0;
      bit_q   <= '0;
      led_q   <= '0;
      rcnt_q  <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      nbuf_q  <= nbuf_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      led_q   <= led_d;
      rcnt_q  <= rcnt_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pix_rd   = rd_q;
  assign pix_addr = addr_q;
  assign dout     = dout_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
